// File: rtl/side_ch_pkg.sv
// Shared definitions for the side-channel FIFO write arbiter: header layout,
// FSM states and the admission margin.
package side_ch_pkg;

    localparam logic [7:0] HDR_MAGIC = 8'h5C;

    localparam int HDR_MAGIC_LSB = 56;
    localparam int HDR_SRC_LSB   = 48;
    localparam int HDR_SEQ_LSB   = 32;
    localparam int HDR_LEN_LSB   = 16;

    // Extra free words required beyond the frame itself: covers the word in
    // flight in the output register and the lag of the FIFO count.
    localparam int FIT_MARGIN = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_PAD
    } state_t;

    function automatic logic [63:0] build_header(
        input logic [7:0]  src,
        input logic [15:0] seq,
        input logic [15:0] len
    );
        logic [63:0] h;
        h = '0;
        h[HDR_MAGIC_LSB +: 8] = HDR_MAGIC;
        h[HDR_SRC_LSB   +: 8] = src;
        h[HDR_SEQ_LSB   +: 16] = seq;
        h[HDR_LEN_LSB   +: 16] = len;
        return h;
    endfunction

endpackage

// File: rtl/side_ch_rr_pick.sv
// Combinational round-robin picker: the first requesting source at or after
// rr_ptr (wrapping) wins.
module side_ch_rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic               pick_valid
);

    always_comb begin
        logic [IDX_W-1:0] idx;
        pick       = '0;
        pick_valid = 1'b0;
        idx        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (!pick_valid && req[idx]) begin
                pick[idx]  = 1'b1;
                pick_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/side_ch_wr_arb.sv
// Shares the side-channel capture FIFO write port between several sources,
// admitting whole frames only and prefixing each with a header word.
module side_ch_wr_arb
    import side_ch_pkg::*;
#(
    parameter int NUM_REQ                = 3,
    parameter int DATA_WIDTH             = 64,
    parameter int MAX_NUM_DMA_SYMBOL     = 8192,
    parameter int MAX_BIT_NUM_DMA_SYMBOL = 14,
    parameter int LEN_WIDTH              = 10,
    parameter int WD_CYCLES              = 1024
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              enable,
    input  logic                              drop_on_full,
    input  logic [NUM_REQ-1:0]                req,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]      req_len,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_data,
    input  logic [NUM_REQ-1:0]                req_data_valid,
    output logic [NUM_REQ-1:0]                grant,
    output logic [NUM_REQ-1:0]                req_drop,
    input  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] m_axis_data_count,
    output logic [DATA_WIDTH-1:0]             data_to_ps,
    output logic                              data_to_ps_valid,
    output logic                              busy,
    output logic [15:0]                       seq_num,
    output logic [15:0]                       drop_cnt
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W  = $clog2(WD_CYCLES) + 1;

    state_t state, state_nxt;

    logic [LEN_WIDTH-1:0]  len_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

    logic [NUM_REQ-1:0]    pick_req, pick_oh;
    logic                  pick_valid, fits, accept, wd_expired, last_word;
    logic [IDX_W-1:0]      pick_idx, rr_adv, rr_ptr, rr_nxt, src_q, src_nxt;
    logic [LEN_WIDTH-1:0]  pick_len, len_q, len_nxt, rem_q, rem_nxt;
    logic [WD_W-1:0]       wd_q, wd_nxt;
    logic [NUM_REQ-1:0]    grant_nxt, req_drop_nxt;
    logic [DATA_WIDTH-1:0] dout_nxt;
    logic                  dvalid_nxt;
    logic [15:0]           seq_nxt, drop_cnt_nxt;

    genvar g;
    generate
        for (g = 0; g < NUM_REQ; g++) begin : g_unpack
            assign len_arr[g]  = req_len[g*LEN_WIDTH +: LEN_WIDTH];
            assign data_arr[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // A source dropped last cycle is masked so one request is never dropped twice in a row.
    assign pick_req = req & ~req_drop;

    side_ch_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req        (pick_req),
        .rr_ptr     (rr_ptr),
        .pick       (pick_oh),
        .pick_valid (pick_valid)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_oh[i]) pick_idx = IDX_W'(i);
        end
    end

    assign pick_len   = len_arr[pick_idx];
    assign fits       = (32'(m_axis_data_count) + 32'(pick_len) + 32'(FIT_MARGIN))
                        <= 32'(MAX_NUM_DMA_SYMBOL);
    assign rr_adv     = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
    assign accept     = (state == ST_DATA) && grant[src_q] && req_data_valid[src_q];
    assign wd_expired = (wd_q == WD_W'(WD_CYCLES - 1));
    assign last_word  = (rem_q == LEN_WIDTH'(1));
    assign busy       = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (enable && pick_valid && fits) state_nxt = ST_HDR;
            ST_HDR:  state_nxt = (len_q == '0) ? ST_IDLE : ST_DATA;
            ST_DATA: begin
                if (accept) begin
                    if (last_word) state_nxt = ST_IDLE;
                end else if (wd_expired) begin
                    state_nxt = ST_PAD;
                end
            end
            ST_PAD:  if (last_word) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Next values for every registered output and the frame bookkeeping.
    always_comb begin
        grant_nxt    = grant;
        req_drop_nxt = '0;
        dout_nxt     = data_to_ps;
        dvalid_nxt   = 1'b0;
        seq_nxt      = seq_num;
        drop_cnt_nxt = drop_cnt;
        rr_nxt       = rr_ptr;
        src_nxt      = src_q;
        len_nxt      = len_q;
        rem_nxt      = rem_q;
        wd_nxt       = wd_q;
        case (state)
            ST_IDLE: begin
                if (enable && pick_valid) begin
                    if (fits) begin
                        grant_nxt  = pick_oh;
                        src_nxt    = pick_idx;
                        len_nxt    = pick_len;
                        rem_nxt    = pick_len;
                        wd_nxt     = '0;
                        dout_nxt   = DATA_WIDTH'(build_header(8'(pick_idx), seq_num, 16'(pick_len)));
                        dvalid_nxt = 1'b1;
                        seq_nxt    = seq_num + 16'd1;
                        rr_nxt     = rr_adv;
                    end else if (drop_on_full) begin
                        req_drop_nxt = pick_oh;
                        drop_cnt_nxt = (drop_cnt == 16'hFFFF) ? drop_cnt : drop_cnt + 16'd1;
                        rr_nxt       = rr_adv;
                    end
                end
            end
            ST_HDR: begin
                if (len_q == '0) grant_nxt = '0;
            end
            ST_DATA: begin
                if (accept) begin
                    dout_nxt   = data_arr[src_q];
                    dvalid_nxt = 1'b1;
                    rem_nxt    = rem_q - 1'b1;
                    wd_nxt     = '0;
                    if (last_word) grant_nxt = '0;
                end else begin
                    wd_nxt = wd_q + 1'b1;
                end
            end
            ST_PAD: begin
                dout_nxt   = '0;
                dvalid_nxt = 1'b1;
                rem_nxt    = rem_q - 1'b1;
                if (last_word) grant_nxt = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant            <= '0;
            req_drop         <= '0;
            data_to_ps       <= '0;
            data_to_ps_valid <= 1'b0;
            seq_num          <= '0;
            drop_cnt         <= '0;
            rr_ptr           <= '0;
            src_q            <= '0;
            len_q            <= '0;
            rem_q            <= '0;
            wd_q             <= '0;
        end else begin
            grant            <= grant_nxt;
            req_drop         <= req_drop_nxt;
            data_to_ps       <= dout_nxt;
            data_to_ps_valid <= dvalid_nxt;
            seq_num          <= seq_nxt;
            drop_cnt         <= drop_cnt_nxt;
            rr_ptr           <= rr_nxt;
            src_q            <= src_nxt;
            len_q            <= len_nxt;
            rem_q            <= rem_nxt;
            wd_q             <= wd_nxt;
        end
    end

endmodule

// File: doc/side_ch_wr_arb.md
# side_ch_wr_arb

Write-port arbiter and frame sequencer for the side-channel capture FIFO (the m_axis buffer feeding the PS DMA). It shares the single `data_to_ps` / `data_to_ps_valid` write port between NUM_REQ capture sources (CSI, equalizer, IQ). Each source request is admitted only when the FIFO has room for the whole frame. Every admitted frame is prefixed with one header word and written atomically, so frames from different sources are never interleaved.

## Interface
- NUM_REQ, 3, number of requesters; source id = requester index
- DATA_WIDTH, 64, FIFO word width
- MAX_NUM_DMA_SYMBOL, 8192, FIFO depth in words
- MAX_BIT_NUM_DMA_SYMBOL, 14, width of the FIFO count
- LEN_WIDTH, 10, payload length field width
- WD_CYCLES, 1024, per-word data watchdog
- Clocking (already decided): one clock; reset is asynchronous and active-high.
- clk  in  1  single clock, same domain as the m_axis FIFO
- rst  in  1  asynchronous active-high reset
- enable  in  1  0 = no new grants; a frame already in progress completes
- drop_on_full  in  1  1 = reject a request that does not fit; 0 = hold it until it fits
- req  in  NUM_REQ  level request per source
- req_len  in  NUM_REQ*LEN_WIDTH  payload words per source, excluding header; must be stable while req is high
- req_data  in  NUM_REQ*DATA_WIDTH  payload word per source
- req_data_valid  in  NUM_REQ  payload word strobe
- grant  out  NUM_REQ  one-hot, registered, held for the whole frame
- req_drop  out  NUM_REQ  1-cycle reject pulse
- m_axis_data_count  in  MAX_BIT_NUM_DMA_SYMBOL  FIFO fill level
- data_to_ps  out  DATA_WIDTH  FIFO write data, registered
- data_to_ps_valid  out  1  FIFO write strobe, registered
- busy  out  1  high whenever state ≠ IDLE
- seq_num  out  16  frame sequence counter; wraps
- drop_cnt  out  16  rejected-request counter; saturates at 16'hFFFF

## Operation
- States:
  - IDLE → HDR when enable is high and a source is picked.
  - HDR → DATA, or HDR → IDLE if len = 0.
  - DATA → PAD on watchdog expiry.
  - DATA → IDLE when the last word is accepted.
  - PAD → IDLE after the last pad word.
- Pick (IDLE): round-robin over the sources with req high, starting at rr_ptr. rr_ptr resets to 0 and becomes granted+1 (mod NUM_REQ) on each grant.
- Fit check: free = MAX_NUM_DMA_SYMBOL − m_axis_data_count. A frame fits when free ≥ len+3; the +3 covers in-flight and count-lag margin.
  - Picked source fits: grant it; latch src, len; move to HDR.
  - Picked source does not fit, drop_on_full=1: pulse req_drop[src], increment drop_cnt, advance rr_ptr, stay in IDLE. No source may be dropped twice in consecutive cycles; the requester must deassert req.
  - Picked source does not fit, drop_on_full=0: stay in IDLE and re-evaluate every cycle. rr_ptr does not advance.
- HDR: write the header {8'h5C, src[7:0], seq_num, 6'b0, len[9:0], 16'h0000} (MSB first). seq_num increments after the header is written.
- DATA: a word is accepted when grant[src] & req_data_valid[src]; it is written one cycle later. Valid on any non-granted source is ignored, and words beyond len are ignored after grant drops.
- Watchdog: resets on each accepted word. After WD_CYCLES cycles with no word, enter PAD and write 64'h0 words for the remaining count, one per cycle, so the frame length always equals the header len.
- rst mid-frame: all state clears immediately and the partial frame remains in the FIFO. FIFO flush is the system-level reset's job.

## Timing
- Reset values: grant=0, req_drop=0, data_to_ps=0, data_to_ps_valid=0, busy=0, seq_num=0, drop_cnt=0, rr_ptr=0.
- Grant latency: grant rises 1 cycle after the pick cycle. The header strobe occurs in that same cycle.
- The first payload word can be accepted in the cycle after the header. Write latency is 1 cycle after acceptance.
- grant falls the cycle after the last word is accepted. The next pick is evaluated in that cycle, giving a minimum 1-cycle gap between frames.
- Back-to-back frame: 1 header + len words + 1 idle cycle.
- A simultaneous req rising on the currently granted source during its DATA state is not a new request until IDLE.

## Structure
- Shared package side_ch_pkg holds:
  - HDR_MAGIC = 8'h5C
  - the state enum
  - header field offsets
  - the FIT_MARGIN = 3 constant
- One sub-module, side_ch_rr_pick: a combinational round-robin priority picker (req vector, rr_ptr → one-hot pick plus valid).

## Test plan
- Single frame: source 1 with len=4 and continuous valid → header 0x5C01_0000_0004_0000, then 4 payload words; grant[1] high for 5 cycles; seq_num=1.
- Round robin: all 3 sources requesting, len=2 each → grant order 0,1,2,0; seq_num increments per frame; no interleaving.
- Full FIFO: count=8190, len=4.
  - drop_on_full=1 → req_drop pulse, drop_cnt=1, no write.
  - drop_on_full=0 → held; count drops to 8180 → frame written.
- Watchdog: len=8, source stops after 3 words → after 1024 idle cycles, 5 zero words are written; busy falls.
- enable low mid-frame → frame completes, then no grant while req stays high. Reset asserted mid-DATA → all outputs return to reset values in the same cycle.
- len=0 → header-only frame; grant high for 1 cycle.
